mem_arbiter8: RTL and testbench
===============================

Name: mem_arbiter8

Overview:
- Round-robin arbiter that shares one memory port among up to 8 requesters (fetch, load/store, test-bench masters) in the memtest harness.
- Drives the 3-bit select that steers the per-requester address/write-data/write-enable buses through 8:1 muxes onto the shared port.
- Runs the valid/ready handshake toward memory.
- Returns a completion or timeout pulse to the granted requester.

Parameters:
- TIMEOUT, 255: WAIT cycles without mem_ready_i before the transaction is abandoned; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  8  per-requester request level; bit n = requester n.
- mem_ready_i  in  1  memory accepts and completes the presented transaction this cycle.
- grant_o  out  8  one-hot grant; 0 when no transaction is active.
- sel_o  out  3  index of granted requester; feeds the 8:1 mux select lines.
- mem_valid_o  out  1  transaction presented to memory.
- done_o  out  8  one-cycle completion pulse, one-hot to the served requester.
- err_o  out  8  one-cycle timeout pulse, one-hot to the abandoned requester.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (sync, rst_i high at an edge): state=IDLE, ptr=0, cnt=0, grant_o=0, sel_o=0, mem_valid_o=0, done_o=0, err_o=0, busy_o=0. Overrides every other event, including mid-WAIT; mem_valid_o drops on that edge with no done/err pulse.
- All outputs are registered.
- ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, ..., wrapping mod 8.
- IDLE:
  - If req_i==0, remain in IDLE; sel_o holds its last value.
  - Otherwise pick the first set bit in search order → idx. Next edge: grant_o=1<<idx, sel_o=idx, mem_valid_o=1, cnt=0, state=WAIT.
  - Latency: req_i seen in cycle N → grant/mem_valid high in N+1.
- WAIT:
  - grant_o, sel_o and mem_valid_o are held stable.
  - req_i changes, including the granted bit dropping, are ignored; a transaction cannot be aborted.
  - If mem_ready_i=1: next edge done_o=1<<sel_o, grant_o=0, mem_valid_o=0, ptr=sel_o+1 (mod 8, 7 wraps to 0), state=DONE.
  - Else if cnt==TIMEOUT-1: same as above, but err_o pulses instead of done_o.
  - Else cnt=cnt+1.
  - mem_ready_i takes precedence over timeout in the same cycle.
- DONE:
  - One cycle; no arbitration. Next edge: done_o=0, err_o=0, state=IDLE.
  - A requester seeing done_o/err_o must update req_i by the end of that cycle; IDLE samples req_i in the following cycle.
- Throughput: minimum 3 cycles per transaction (IDLE, WAIT with ready, DONE).
- Fairness: a requester holding req_i high is served at most once per rotation while others are pending. A sole requester may be served back to back.
- Invariants:
  - grant_o is zero or one-hot.
  - done_o and err_o are never both nonzero.
  - mem_valid_o == (state==WAIT).

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - NUM_REQ=8, SEL_W=3.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and base[2:0]; outputs found and idx[2:0]. Rotate req right by base, priority-encode from bit 0, add base mod 8.
- Arbiter FSM, pointer and counter stay in mem_arbiter8.

Test Plan:
- Reset, req_i=8'h01, mem_ready_i=1 constant → cycle+1 grant_o=8'h01, sel_o=0, mem_valid_o=1; cycle+2 done_o=8'h01, mem_valid_o=0; cycle+3 busy_o=0.
- req_i=8'hFF held, mem_ready_i=1 → sel_o sequence 0,1,...,7,0 with one grant every 3 cycles; each done_o bit pulses exactly once per 24 cycles.
- After requester 5 completes (ptr=6), req_i=8'h21 → grant requester 0 first, then requester 5.
- TIMEOUT=4, single req bit 2, mem_ready_i=0 → mem_valid_o high for 4 cycles, then err_o=8'h04 for one cycle, done_o stays 0, next search starts at 3.
- TIMEOUT=4, mem_ready_i=1 in the 4th WAIT cycle → done_o=8'h04, err_o=0.
- rst_i asserted during WAIT with sel_o=6 → next cycle all outputs 0; with req_i=8'hC1, next grant is requester 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Included by the round-robin picker and by the arbiter top.
package mem_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: the first set request bit,
// searching upward from base and wrapping modulo 8.
module rr_pick8
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   base,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  // Doubling the vector makes a right rotation by base a plain part-select.
  assign dbl = {req, req};
  assign rot = dbl[base +: NUM_REQ];

  // Scanning from the top down leaves the lowest set bit in off.
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
  end

  assign found = |req;
  assign idx   = base + off;

endmodule

// File: rtl/mem_arbiter8.sv
// Round-robin arbiter sharing one memory port among 8 requesters,
// with valid/ready handshake, timeout, and per-requester done/err pulses.
module mem_arbiter8
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               mem_ready_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               mem_valid_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic               busy_o
);

  state_t             state, nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               found;
  logic [SEL_W-1:0]   pick_idx;
  logic               timeout;

  logic [NUM_REQ-1:0] grant_nxt, done_nxt, err_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               valid_nxt, busy_nxt;

  rr_pick8 u_pick (
    .req   (req_i),
    .base  (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  // All outputs are registered alongside the state, pointer and counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_o     <= '0;
      sel_o       <= '0;
      mem_valid_o <= 1'b0;
      done_o      <= '0;
      err_o       <= '0;
      busy_o      <= 1'b0;
    end else begin
      state       <= nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      grant_o     <= grant_nxt;
      sel_o       <= sel_nxt;
      mem_valid_o <= valid_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      busy_o      <= busy_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          nxt     = WAIT;
          cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (mem_ready_i || timeout) begin
          nxt     = DONE;
          ptr_nxt = sel_o + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Ready wins over timeout when both happen in the same WAIT cycle.
  always_comb begin
    grant_nxt = grant_o;
    sel_nxt   = sel_o;
    valid_nxt = mem_valid_o;
    done_nxt  = '0;
    err_nxt   = '0;
    busy_nxt  = (nxt != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = onehot(pick_idx);
          sel_nxt   = pick_idx;
          valid_nxt = 1'b1;
        end else begin
          grant_nxt = '0;
          valid_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (mem_ready_i) begin
          done_nxt  = onehot(sel_o);
          grant_nxt = '0;
          valid_nxt = 1'b0;
        end else if (timeout) begin
          err_nxt   = onehot(sel_o);
          grant_nxt = '0;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        grant_nxt = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter8.sv
// Self-checking bench for mem_arbiter8: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter8;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic [7:0] grant, done, err;
  logic [2:0] sel;
  logic       valid, busy;

  int compared = 0;
  int mismatched = 0;

  // Model: who owns the port, how long it has waited, and whether the
  // one-cycle retire slot after completion is in progress.
  int         mPtr = 0;
  int         mOwner = -1;
  int         mWaited = 0;
  bit         mRetire = 0;
  logic [7:0] eGrant, eDone, eErr;
  logic [2:0] eSel;
  logic       eValid, eBusy;

  mem_arbiter8 #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .mem_ready_i (ready),
    .grant_o     (grant),
    .sel_o       (sel),
    .mem_valid_o (valid),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic [7:0] r, input logic rdy, input logic rs);
    eDone = '0;
    eErr  = '0;
    if (rs) begin
      mPtr = 0; mOwner = -1; mRetire = 0;
      eGrant = '0; eSel = '0; eValid = 0; eBusy = 0;
    end else if (mRetire) begin
      mRetire = 0;
      eBusy   = 0;
    end else if (mOwner >= 0) begin
      mWaited++;
      if (rdy || mWaited == TO) begin
        if (rdy) eDone = 8'(1 << mOwner);
        else     eErr  = 8'(1 << mOwner);
        mPtr    = (mOwner + 1) % 8;
        mOwner  = -1;
        mRetire = 1;
        eGrant  = '0;
        eValid  = 0;
      end
    end else if (r != 0) begin
      int pick = -1;
      for (int i = 0; i < 8; i++) begin
        int j = (mPtr + i) % 8;
        if (pick < 0 && r[j]) pick = j;
      end
      mOwner  = pick;
      mWaited = 0;
      eGrant  = 8'(1 << pick);
      eSel    = 3'(pick);
      eValid  = 1;
      eBusy   = 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, and check.
  task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic rs);
    req = r; ready = rdy; rst = rs;
    @(posedge clk);
    #1;
    modelStep(r, rdy, rs);
    checkOutput("grant", grant, eGrant);
    checkOutput("sel", {5'b0, sel}, {5'b0, eSel});
    checkOutput("valid", {7'b0, valid}, {7'b0, eValid});
    checkOutput("done", done, eDone);
    checkOutput("err", err, eErr);
    checkOutput("busy", {7'b0, busy}, {7'b0, eBusy});
    checkOutput("grant_onehot", {7'b0, $onehot0(grant)}, 8'h01);
    checkOutput("done_err_excl", {7'b0, (done != 0 && err != 0)}, 8'h00);
  endtask

  initial begin
    int cntDone [8];

    // Single requester, ready always high.
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("reset_grant", grant, 8'h00);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("single_grant", grant, 8'h01);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("single_done", done, 8'h01);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("single_idle", {7'b0, busy}, 8'h00);

    // All requesters held: rotation 0..7 then 0, each done once per 24 cycles.
    applyStimulus(8'h00, 1'b0, 1'b1);
    foreach (cntDone[k]) cntDone[k] = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(8'hFF, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) if (done[k]) cntDone[k]++;
    end
    for (int k = 0; k < 8; k++) checkOutput("ff_done_once", 8'(cntDone[k]), 8'h01);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    checkOutput("ff_wrap_sel", {5'b0, sel}, 8'h00);

    // Pointer at 6 after requester 5: 8'h21 serves 0 before 5.
    applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (3) applyStimulus(8'h20, 1'b1, 1'b0);
    applyStimulus(8'h21, 1'b1, 1'b0);
    checkOutput("wrap_first", grant, 8'h01);
    repeat (2) applyStimulus(8'h21, 1'b1, 1'b0);
    applyStimulus(8'h21, 1'b1, 1'b0);
    checkOutput("wrap_second", grant, 8'h20);
    repeat (2) applyStimulus(8'h00, 1'b1, 1'b0);

    // Timeout on requester 2, then search resumes at 3.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h04, 1'b0, 1'b0);
    repeat (3) applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("to_valid_held", {7'b0, valid}, 8'h01);
    applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("to_err", err, 8'h04);
    checkOutput("to_no_done", done, 8'h00);
    applyStimulus(8'h09, 1'b0, 1'b0);
    applyStimulus(8'h09, 1'b1, 1'b0);
    checkOutput("to_next_from3", grant, 8'h08);
    repeat (2) applyStimulus(8'h00, 1'b1, 1'b0);

    // Ready arriving in the last allowed WAIT cycle wins over timeout.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h04, 1'b0, 1'b0);
    repeat (3) applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0);
    checkOutput("last_ready_done", done, 8'h04);
    checkOutput("last_ready_err", err, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Reset mid-WAIT with requester 6 granted.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h40, 1'b0, 1'b0);
    applyStimulus(8'h40, 1'b0, 1'b0);
    checkOutput("mid_sel6", {5'b0, sel}, 8'h06);
    applyStimulus(8'hC1, 1'b0, 1'b1);
    checkOutput("mid_rst_valid", {7'b0, valid}, 8'h00);
    applyStimulus(8'hC1, 1'b0, 1'b0);
    checkOutput("mid_rst_regrant", grant, 8'h01);

    // Random traffic with occasional resets and timeouts.
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
